// File: rtl/serial_adder_seq.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through one registered carry,
// with a start/busy/done handshake around an IDLE -> RUN -> DONE sequence.
module serial_adder_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_adder_seq: illegal WIDTH/DIGIT combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    count;

    logic [DIGIT:0]         dsum;
    logic                   c_msb;
    logic [WIDTH+DIGIT-1:0] sum_cat;
    logic [WIDTH-1:0]       sum_nx;

    always_comb begin
        dsum    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry};
        // Sum bit = a ^ b ^ carry_in, so the MSB's carry-in falls out of the digit sum.
        c_msb   = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ dsum[DIGIT-1];
        sum_cat = {dsum[DIGIT-1:0], sum_sh};
        sum_nx  = WIDTH'(sum_cat >> DIGIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            count  <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    sum_sh <= sum_nx;
                    carry  <= dsum[DIGIT];
                    count  <= count + CW'(1);
                    if (count == CW'(N - 1)) begin
                        sum   <= sum_nx;
                        cout  <= dsum[DIGIT];
                        ovf   <= c_msb ^ dsum[DIGIT];
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Bench for serial_adder_seq: three configurations (8/1, 8/4, 3/1) checked
// against a signed/unsigned arithmetic model.
module tb_serial_adder_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       st8, sb8, ci8, bz8, dn8, co8, ov8;
    logic [7:0] a8, b8, s8;
    logic       stq, sbq, ciq, bzq, dnq, coq, ovq;
    logic [7:0] aq, bq, sq;
    logic       st3, sb3, ci3, bz3, dn3, co3, ov3;
    logic [2:0] a3, b3, s3;

    int errors = 0;
    int checks = 0;
    int nd8 = 0, ndq = 0, nd3 = 0;

    serial_adder_seq #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .sub(sb8), .a(a8), .b(b8),
        .cin(ci8), .busy(bz8), .done(dn8), .sum(s8), .cout(co8), .ovf(ov8));
    serial_adder_seq #(.WIDTH(8), .DIGIT(4)) uq (
        .clk(clk), .rst_n(rst_n), .start(stq), .sub(sbq), .a(aq), .b(bq),
        .cin(ciq), .busy(bzq), .done(dnq), .sum(sq), .cout(coq), .ovf(ovq));
    serial_adder_seq #(.WIDTH(3), .DIGIT(1)) u3 (
        .clk(clk), .rst_n(rst_n), .start(st3), .sub(sb3), .a(a3), .b(b3),
        .cin(ci3), .busy(bz3), .done(dn3), .sum(s3), .cout(co3), .ovf(ov3));

    always @(posedge clk) begin
        if (dn8) nd8 <= nd8 + 1;
        if (dnq) ndq <= ndq + 1;
        if (dn3) nd3 <= nd3 + 1;
    end

    function automatic void model(input int w, input int op_sub,
                                  input longint av, input longint bv, input int ci,
                                  output longint s, output int co, output int ov);
        longint m    = (longint'(1) << w) - 1;
        longint h    = longint'(1) << (w - 1);
        longint bx   = op_sub != 0 ? (~bv) & m : bv;
        longint full = av + bx + (op_sub != 0 ? 1 : ci);
        longint sa   = av >= h ? av - 2 * h : av;
        longint sbv  = bv >= h ? bv - 2 * h : bv;
        longint r    = op_sub != 0 ? sa - sbv : sa + sbv + ci;
        s  = full & m;
        co = int'((full >> w) & 1);
        ov = (r >= h || r < -h) ? 1 : 0;
    endfunction

    function automatic logic done_of(input int sel);
        return sel == 0 ? dn8 : (sel == 1 ? dnq : dn3);
    endfunction

    task automatic run_op(input int sel, input logic op_sub, input logic [7:0] aa,
                          input logic [7:0] bb, input logic ci,
                          output logic [7:0] s, output logic co, output logic ov,
                          output int lat);
        case (sel)
            0: begin st8 = 1; sb8 = op_sub; a8 = aa; b8 = bb; ci8 = ci; end
            1: begin stq = 1; sbq = op_sub; aq = aa; bq = bb; ciq = ci; end
            default: begin st3 = 1; sb3 = op_sub; a3 = aa[2:0]; b3 = bb[2:0]; ci3 = ci; end
        endcase
        @(posedge clk); #1;
        st8 = 0; stq = 0; st3 = 0;
        case (sel)
            0: begin a8 = 8'($urandom); b8 = 8'($urandom); sb8 = 1'($urandom); ci8 = 1'($urandom); end
            1: begin aq = 8'($urandom); bq = 8'($urandom); sbq = 1'($urandom); ciq = 1'($urandom); end
            default: begin a3 = 3'($urandom); b3 = 3'($urandom); sb3 = 1'($urandom); ci3 = 1'($urandom); end
        endcase
        lat = 1;
        while (!done_of(sel) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (!done_of(sel)) begin
            errors++;
            $display("FAIL done_timeout sel=%0d: no done after %0d cycles", sel, lat);
        end
        s  = sel == 0 ? s8 : (sel == 1 ? sq : {5'b0, s3});
        co = sel == 0 ? co8 : (sel == 1 ? coq : co3);
        ov = sel == 0 ? ov8 : (sel == 1 ? ovq : ov3);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        st8 = 0; sb8 = 0; ci8 = 0; a8 = 0; b8 = 0;
        stq = 0; sbq = 0; ciq = 0; aq = 0; bq = 0;
        st3 = 0; sb3 = 0; ci3 = 0; a3 = 0; b3 = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bz8, dn8, s8, co8, ov8} !== 12'h0) begin
            errors++;
            $display("FAIL reset_u8: got %h want 0", {bz8, dn8, s8, co8, ov8});
        end
        checks++;
        if ({bzq, dnq, sq, coq, ovq} !== 12'h0) begin
            errors++;
            $display("FAIL reset_u84: got %h want 0", {bzq, dnq, sq, coq, ovq});
        end
        checks++;
        if ({bz3, dn3, s3, co3, ov3} !== 7'h0) begin
            errors++;
            $display("FAIL reset_u3: got %h want 0", {bz3, dn3, s3, co3, ov3});
        end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_spec_vectors();
        logic [7:0] s;
        logic co, ov;
        int lat;
        run_op(0, 1'b0, 8'hFF, 8'h01, 1'b0, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {8'h00, 1'b1, 1'b0} || lat != 9) begin
            errors++;
            $display("FAIL vec1: sum=%h cout=%b ovf=%b lat=%0d want 00 1 0 lat 9", s, co, ov, lat);
        end
        run_op(0, 1'b0, 8'h7F, 8'h01, 1'b0, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {8'h80, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL vec2_add: sum=%h cout=%b ovf=%b want 80 0 1", s, co, ov);
        end
        run_op(0, 1'b1, 8'h05, 8'h07, 1'b1, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {8'hFE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL vec2_sub: sum=%h cout=%b ovf=%b want FE 0 0", s, co, ov);
        end
        run_op(1, 1'b0, 8'h3C, 8'h0F, 1'b1, s, co, ov, lat);
        checks++;
        if ({s, co} !== {8'h4C, 1'b0} || lat != 3) begin
            errors++;
            $display("FAIL vec3_digit4: sum=%h cout=%b lat=%0d want 4C 0 lat 3", s, co, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] s, ra, rb;
        logic co, ov, rs, rc;
        int lat, eco, eov;
        longint es;
        for (int i = 0; i < 60; i++) begin
            int sel = i % 2;
            ra = 8'($urandom); rb = 8'($urandom);
            rs = 1'($urandom); rc = 1'($urandom);
            model(8, int'(rs), longint'(ra), longint'(rb), int'(rc), es, eco, eov);
            run_op(sel, rs, ra, rb, rc, s, co, ov, lat);
            checks++;
            if (s !== 8'(es) || co !== 1'(eco) || ov !== 1'(eov) || lat != (sel == 0 ? 9 : 3)) begin
                errors++;
                $display("FAIL random sel=%0d sub=%b a=%h b=%h cin=%b: got %h %b %b lat %0d want %h %0d %0d",
                         sel, rs, ra, rb, rc, s, co, ov, lat, 8'(es), eco, eov);
            end
        end
    endtask

    task automatic test_ignore_start();
        int n0 = nd8;
        int k = 0;
        st8 = 1; sb8 = 0; a8 = 8'h12; b8 = 8'h34; ci8 = 0;
        @(posedge clk); #1;
        st8 = 0;
        repeat (2) @(posedge clk);
        #1;
        st8 = 1; a8 = 8'hAA; b8 = 8'h55; sb8 = 1;
        @(posedge clk); #1;
        st8 = 0;
        while (!dn8 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (s8 !== 8'h46 || co8 !== 1'b0 || ov8 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_result: sum=%h cout=%b ovf=%b want 46 0 0", s8, co8, ov8);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (nd8 - n0 != 1 || bz8 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_pulses: done_count=%0d busy=%b want 1 0", nd8 - n0, bz8);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] s;
        logic co, ov;
        int lat;
        int n0;
        run_op(0, 1'b0, 8'hF0, 8'h0F, 1'b1, s, co, ov, lat);
        n0 = nd8;
        st8 = 1; sb8 = 0; a8 = 8'h21; b8 = 8'h43; ci8 = 0;
        @(posedge clk); #1;
        st8 = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        checks++;
        if ({bz8, dn8, s8, co8, ov8} !== 12'h0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     bz8, dn8, s8, co8, ov8);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (nd8 != n0 || bz8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: done_count=%0d busy=%b want %0d 0", nd8, bz8, n0);
        end
        run_op(0, 1'b0, 8'h21, 8'h43, 1'b0, s, co, ov, lat);
        checks++;
        if ({s, co, ov} !== {8'h64, 1'b0, 1'b0} || lat != 9) begin
            errors++;
            $display("FAIL reset_recover: sum=%h cout=%b ovf=%b lat=%0d want 64 0 0 lat 9", s, co, ov, lat);
        end
    endtask

    task automatic test_exhaustive_w3();
        logic [7:0] s;
        logic co, ov;
        int lat, eco, eov, n0;
        longint es;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            model(3, int'(v[7]), longint'(v[2:0]), longint'(v[5:3]), int'(v[6]), es, eco, eov);
            n0 = nd3;
            run_op(2, v[7], {5'b0, v[2:0]}, {5'b0, v[5:3]}, v[6], s, co, ov, lat);
            checks++;
            if (s[2:0] !== 3'(es) || co !== 1'(eco) || ov !== 1'(eov) || lat != 4 || nd3 - n0 != 1) begin
                errors++;
                $display("FAIL w3 sub=%b a=%0d b=%0d cin=%b: got %0d %b %b lat %0d pulses %0d want %0d %0d %0d",
                         v[7], v[2:0], v[5:3], v[6], s[2:0], co, ov, lat, nd3 - n0, es, eco, eov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_random();
        test_ignore_start();
        test_reset_mid_run();
        test_exhaustive_w3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
